vsdserializer_scheduler: RTL and testbench

Round-robin scheduler that feeds the 10-bit load-and-shift serializer (vsdserializer_v1) from up to NUM_REQ word sources.
- Generates the serializer's one-cycle load strobe at a fixed frame period of WIDTH clocks.
- Selects which requester's word is presented on each load and acknowledges it.
- Fills empty frames with IDLE_WORD so the serial line never stalls mid-link.
- Sits between the packet/word producers and the serializer datapath.

---
 rtl/vsdserializer_scheduler_if.sv | 28 ++
 rtl/vsdserializer_scheduler.sv | 113 +++++++++++
 tb/tb_vsdserializer_scheduler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vsdserializer_scheduler_if.sv
// Word-source / serializer handshake bundle for the round-robin frame scheduler.
// The producer side (master) drives en/req/req_data; the scheduler (slave) drives the rest.
interface vsdserializer_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 10
);
   localparam int IDW = $clog2(NUM_REQ);

   logic                     en;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       ack;
   logic                     ser_load;
   logic [WIDTH-1:0]         ser_data;
   logic [IDW-1:0]           grant_id;
   logic                     busy;
   logic [7:0]               frames_sent;

   modport master (
      output en, req, req_data,
      input  ack, ser_load, ser_data, grant_id, busy, frames_sent
   );

   modport slave (
      input  en, req, req_data,
      output ack, ser_load, ser_data, grant_id, busy, frames_sent
   );
endinterface

// File: rtl/vsdserializer_scheduler.sv
// Round-robin scheduler producing the load strobe and parallel word for a
// WIDTH-bit load-and-shift serializer; empty frames carry IDLE_WORD.
//
// state   | meaning
// S_IDLE  | framing stopped, waiting for en
// S_LOAD  | one-cycle load strobe, arbitration and ack happen here
// S_SHIFT | serializer shifting, bit_cnt runs 1..WIDTH-1
module vsdserializer_scheduler #(
   parameter int               NUM_REQ   = 4,
   parameter int               WIDTH     = 10,
   parameter logic [WIDTH-1:0] IDLE_WORD = 10'b0011111010
) (
   input  logic                       clk,
   input  logic                       rst,
   vsdserializer_scheduler_if.slave   bus
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [7:0]       frames_q, frames_d;

   logic             is_load;
   logic             found;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   cand;
   logic [WIDTH-1:0] load_word;

   assign is_load = (state_q == S_LOAD);

   // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign load_word = found ? bus.req_data[int'(win)*WIDTH +: WIDTH] : IDLE_WORD;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      data_d    = data_q;
      frames_d  = frames_q;
      case (state_q)
         S_IDLE: begin
            if (bus.en) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d   = S_SHIFT;
            bit_cnt_d = CW'(1);
            data_d    = load_word;
            if (found) begin
               grant_d  = win;
               rr_ptr_d = (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;
               frames_d = frames_q + 8'd1;
            end
         end
         S_SHIFT: begin
            if (bit_cnt_q == CW'(WIDTH-1)) begin
               bit_cnt_d = '0;
               state_d   = bus.en ? S_LOAD : S_IDLE;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         data_q    <= '0;
         frames_q  <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         data_q    <= data_d;
         frames_q  <= frames_d;
      end
   end

   // Strobe and ack decode straight from state so reset kills them without waiting for a clock.
   assign bus.ser_load    = is_load;
   assign bus.ser_data    = is_load ? load_word : data_q;
   assign bus.ack         = (is_load && found) ? (NUM_REQ'(1) << win) : '0;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.grant_id    = grant_q;
   assign bus.frames_sent = frames_q;
endmodule

// File: tb/tb_vsdserializer_scheduler.sv
// Directed bench for vsdserializer_scheduler: expected loads are queued as
// stimulus is set up and popped when the scheduler raises ser_load.
module tb_vsdserializer_scheduler;
   localparam int         NR   = 4;
   localparam int         W    = 10;
   localparam logic [9:0] IDLE = 10'b0011111010;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vsdserializer_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus_if ();

   vsdserializer_scheduler #(.NUM_REQ(NR), .WIDTH(W), .IDLE_WORD(IDLE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct packed {
      logic [9:0] data;
      logic [3:0] ack;
      logic [1:0] gid;
      logic [7:0] frames;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [9:0] d, input logic [3:0] a, input logic [1:0] g,
                       input logic [7:0] f);
      sb.push_back('{data: d, ack: a, gid: g, frames: f});
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for the next load strobe, then checks it against the queue head.
   task automatic load_check(input string tag, output int waited);
      exp_t e;
      waited = 0;
      @(negedge clk);
      while (bus_if.ser_load !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk({tag, "_load_seen"}, 32'(bus_if.ser_load), 1);
      if (bus_if.ser_load !== 1'b1) return;
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk({tag, "_ser_data"}, 32'(bus_if.ser_data), 32'(e.data));
      chk({tag, "_ack"}, 32'(bus_if.ack), 32'(e.ack));
      next_edge();
      chk({tag, "_grant_id"}, 32'(bus_if.grant_id), 32'(e.gid));
      chk({tag, "_frames_sent"}, 32'(bus_if.frames_sent), 32'(e.frames));
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus_if.busy !== 1'b0 && n < 30) begin
         next_edge();
         n++;
      end
      chk("idle_reached", 32'(bus_if.busy), 0);
   endtask

   task automatic rst_pulse();
      next_edge();
      rst = 1'b1;
      next_edge();
      rst = 1'b0;
   endtask

   initial begin
      int   w;
      logic seen;

      // Reset with random inputs
      rst             = 1'b1;
      bus_if.en       = 1'b0;
      bus_if.req      = 4'($urandom);
      bus_if.req_data = 40'({$urandom(), $urandom()});
      repeat (3) begin
         @(negedge clk);
         bus_if.en  = 1'($urandom_range(0, 1));
         bus_if.req = 4'($urandom);
      end
      @(negedge clk);
      chk("rst_ser_load", 32'(bus_if.ser_load), 0);
      chk("rst_ser_data", 32'(bus_if.ser_data), 0);
      chk("rst_ack", 32'(bus_if.ack), 0);
      chk("rst_grant_id", 32'(bus_if.grant_id), 0);
      chk("rst_busy", 32'(bus_if.busy), 0);
      chk("rst_frames", 32'(bus_if.frames_sent), 0);
      next_edge();
      bus_if.en  = 1'b0;
      bus_if.req = '0;
      rst        = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus_if.ser_load !== 1'b0) seen = 1'b1;
      end
      chk("en_low_no_load", 32'(seen), 0);

      // Single requester 2, dropped after ack
      bus_if.req_data           = '0;
      bus_if.req_data[2*W +: W] = 10'h2A5;
      bus_if.req                = 4'b0100;
      push(10'h2A5, 4'b0100, 2'd2, 8'd1);
      bus_if.en = 1'b1;
      load_check("t2_grant", w);
      bus_if.req = '0;
      push(IDLE, 4'b0000, 2'd2, 8'd1);
      repeat (3) @(negedge clk);
      chk("t2_data_held", 32'(bus_if.ser_data), 32'h2A5);
      chk("t2_ack_shift", 32'(bus_if.ack), 0);
      chk("t2_busy_shift", 32'(bus_if.busy), 1);
      load_check("t2_idle", w);
      bus_if.en = 1'b0;
      wait_idle();
      rst_pulse();

      // All four requesters held high: 0,1,2,3,0 every 10 clocks
      bus_if.req_data = {10'h004, 10'h003, 10'h002, 10'h001};
      bus_if.req      = 4'hF;
      push(10'h001, 4'b0001, 2'd0, 8'd1);
      push(10'h002, 4'b0010, 2'd1, 8'd2);
      push(10'h003, 4'b0100, 2'd2, 8'd3);
      push(10'h004, 4'b1000, 2'd3, 8'd4);
      push(10'h001, 4'b0001, 2'd0, 8'd5);
      bus_if.en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         load_check($sformatf("t3_rr%0d", i), w);
         if (i > 0) chk($sformatf("t3_period%0d", i), 32'(w), 9);
      end

      // en dropped at bit_cnt 4: frame completes, then idle
      repeat (3) next_edge();
      bus_if.en = 1'b0;
      repeat (5) next_edge();
      chk("t4_busy_last_bit", 32'(bus_if.busy), 1);
      next_edge();
      chk("t4_busy_fell", 32'(bus_if.busy), 0);
      chk("t4_no_load", 32'(bus_if.ser_load), 0);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus_if.ser_load !== 1'b0) seen = 1'b1;
      end
      chk("t4_stays_idle", 32'(seen), 0);
      next_edge();
      push(10'h002, 4'b0010, 2'd1, 8'd6);
      bus_if.en = 1'b1;
      load_check("t4_restart", w);
      chk("t4_restart_gap", 32'(w), 1);

      // Reset mid-frame at bit_cnt 5 after grant to requester 1
      repeat (4) next_edge();
      rst = 1'b1;
      #1;
      chk("t5_ser_load", 32'(bus_if.ser_load), 0);
      chk("t5_busy", 32'(bus_if.busy), 0);
      chk("t5_ack", 32'(bus_if.ack), 0);
      chk("t5_frames", 32'(bus_if.frames_sent), 0);
      chk("t5_grant_id", 32'(bus_if.grant_id), 0);
      push(10'h001, 4'b0001, 2'd0, 8'd1);
      next_edge();
      rst = 1'b0;
      load_check("t5_first_grant", w);
      bus_if.en = 1'b0;
      wait_idle();
      rst_pulse();

      // frames_sent wrap with occasional idle frames
      bus_if.req_data         = '0;
      bus_if.req_data[0 +: W] = 10'h155;
      bus_if.req              = 4'b0001;
      bus_if.en               = 1'b1;
      for (int i = 1; i <= 257; i++) begin
         push(10'h155, 4'b0001, 2'd0, 8'(i));
         load_check($sformatf("t6_f%0d", i), w);
         if (i % 100 == 0) begin
            bus_if.req = '0;
            push(IDLE, 4'b0000, 2'd0, 8'(i));
            load_check($sformatf("t6_idle%0d", i), w);
            bus_if.req = 4'b0001;
         end
      end
      bus_if.en = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
